// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the two requester ports and the memory port
// seen by mem_arbiter.
//
// Signals (direction as seen from the arbiter, modport slave):
//   pN_valid   in   requester N command valid
//   pN_ready   out  requester N command accepted this cycle
//   pN_we      in   1 = write, 0 = read
//   pN_addr    in   word address [9:0]
//   pN_wdata   in   write data [31:0]
//   pN_rvalid  out  read data valid for requester N
//   pN_rdata   out  read data for requester N [31:0]
//   mem_en     out  memory enable
//   mem_we     out  memory write enable
//   mem_addr   out  memory address [9:0]
//   mem_wdata  out  memory write data [31:0]
//   mem_rdata  in   memory read data, valid the cycle after a read is issued
//   busy       out  a command or read response is in flight
// modport master is the mirror image, used by requesters and the memory.
interface mem_arbiter_if;
  logic        p0_valid;
  logic        p0_ready;
  logic        p0_we;
  logic [9:0]  p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;

  logic        p1_valid;
  logic        p1_ready;
  logic        p1_we;
  logic [9:0]  p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_valid, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_valid, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port arbiter in front of a single-port synchronous
// memory (1024 x 32, one-cycle read latency).
//
// Ports:
//   ACLK    in  system clock, all logic on the rising edge
//   ARESET  in  synchronous active-high reset
//   bus     mem_arbiter_if.slave: requester ports p0/p1, memory port, busy
//
// Behaviour:
//   A command accepted (pN_valid && pN_ready) in cycle T is presented on
//   mem_* in T+1 (mem_en=1). Read data returns from memory in T+2 and is
//   steered to the originating port via a two-stage requester-id tag pipe.
//   The memory never stalls, so one command per cycle is sustained.
//
// Configuration macro MEM_ARB_RR_EN:
//   defined   -> round-robin between p0/p1 when both are valid (rr_ptr)
//   undefined -> fixed priority, p0 wins on contention; no rr_ptr exists
module mem_arbiter (
  input logic         ACLK,
  input logic         ARESET,
  mem_arbiter_if.slave bus
);

  // Arbitration (combinational)
  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic        xfer_we;
  logic [9:0]  xfer_addr;
  logic [31:0] xfer_wdata;

`ifdef MEM_ARB_RR_EN
  // 0 = p0 favoured on contention, 1 = p1 favoured
  logic rr_ptr;

  always_comb begin
    grant1 = !ARESET && bus.p1_valid && (!bus.p0_valid || rr_ptr);
    grant0 = !ARESET && bus.p0_valid && !(bus.p1_valid && rr_ptr);
  end

  // Point at the loser of each transfer; hold on idle cycles.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rr_ptr <= 1'b0;
    end else if (xfer) begin
      rr_ptr <= !grant1;
    end
  end
`else
  always_comb begin
    grant0 = !ARESET && bus.p0_valid;
    grant1 = !ARESET && bus.p1_valid && !bus.p0_valid;
  end
`endif

  always_comb begin
    xfer       = grant0 || grant1;
    xfer_we    = grant1 ? bus.p1_we    : bus.p0_we;
    xfer_addr  = grant1 ? bus.p1_addr  : bus.p0_addr;
    xfer_wdata = grant1 ? bus.p1_wdata : bus.p0_wdata;
  end

  always_comb begin
    bus.p0_ready = grant0;
    bus.p1_ready = grant1;
  end

  // Command stage: drives the memory port directly. Address/data/we hold
  // their last value on idle cycles; only mem_en drops.
  logic        cmd_valid;
  logic        cmd_we;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;

  // Tag pipeline: stage 1 aligns with the read on mem_*, stage 2 with the
  // returning mem_rdata. id 0 = p0, 1 = p1.
  logic tag1_valid;
  logic tag1_id;
  logic tag2_valid;
  logic tag2_id;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cmd_valid  <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      tag1_valid <= 1'b0;
      tag1_id    <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_id    <= 1'b0;
    end else begin
      cmd_valid <= xfer;
      if (xfer) begin
        cmd_we    <= xfer_we;
        cmd_addr  <= xfer_addr;
        cmd_wdata <= xfer_wdata;
      end
      tag1_valid <= xfer && !xfer_we;
      tag1_id    <= grant1;
      tag2_valid <= tag1_valid;
      tag2_id    <= tag1_id;
    end
  end

  always_comb begin
    bus.mem_en    = cmd_valid;
    bus.mem_we    = cmd_we;
    bus.mem_addr  = cmd_addr;
    bus.mem_wdata = cmd_wdata;
  end

  // Responses: rdata is shared, rvalid selects the port. Gated by ARESET so
  // a response due in the reset cycle itself is never signalled.
  always_comb begin
    bus.p0_rdata  = bus.mem_rdata;
    bus.p1_rdata  = bus.mem_rdata;
    bus.p0_rvalid = !ARESET && tag2_valid && !tag2_id;
    bus.p1_rvalid = !ARESET && tag2_valid &&  tag2_id;
    bus.busy      = cmd_valid || tag1_valid || tag2_valid;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter.
// Contains a 1024x32 synchronous memory model with one-cycle read latency.
// Contention expectations follow the MEM_ARB_RR_EN setting of the build.
module tb_mem_arbiter;

  logic ACLK = 1'b0;
  logic ARESET;

  always #5 ACLK = ~ACLK;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus.slave)
  );

  // Memory model
  logic [31:0] mem_array [1024];

  always @(posedge ACLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_array[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_array[bus.mem_addr];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_p0(input logic v, input logic we, input logic [9:0] a, input logic [31:0] d);
    bus.p0_valid = v;
    bus.p0_we    = we;
    bus.p0_addr  = a;
    bus.p0_wdata = d;
  endtask

  task automatic set_p1(input logic v, input logic we, input logic [9:0] a, input logic [31:0] d);
    bus.p1_valid = v;
    bus.p1_we    = we;
    bus.p1_addr  = a;
    bus.p1_wdata = d;
  endtask

  task automatic idle();
    set_p0(1'b0, 1'b0, 10'h000, 32'h0);
    set_p1(1'b0, 1'b0, 10'h000, 32'h0);
  endtask

  // Address-corner stimulus: two writes then two reads, all from p0
  logic        c_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [9:0]  c_addr [4] = '{10'h000, 10'h3FF, 10'h000, 10'h3FF};
  logic [31:0] c_data [4] = '{32'hFFFFFFFF, 32'h00000000, 32'h0, 32'h0};

  // Contention grant pattern, bit i = cycle i
  logic [3:0] exp_g0;
  logic [3:0] exp_g1;

  int hs_cnt;
  int en_cnt;

  initial begin
    ARESET = 1'b1;
    idle();
    cyc();
    cyc();

    // Reset state, requests present while in reset
    set_p0(1'b1, 1'b0, 10'h001, 32'h0);
    set_p1(1'b1, 1'b0, 10'h002, 32'h0);
    #1;
    check1 ("rst_p0_ready",  bus.p0_ready,  1'b0);
    check1 ("rst_p1_ready",  bus.p1_ready,  1'b0);
    check1 ("rst_p0_rvalid", bus.p0_rvalid, 1'b0);
    check1 ("rst_p1_rvalid", bus.p1_rvalid, 1'b0);
    check1 ("rst_mem_en",    bus.mem_en,    1'b0);
    check1 ("rst_mem_we",    bus.mem_we,    1'b0);
    check32("rst_mem_addr",  32'(bus.mem_addr), 32'h0);
    check32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check1 ("rst_busy",      bus.busy,      1'b0);

    // Single write then read; first cycle out of reset accepts a transfer
    cyc();
    ARESET = 1'b0;
    idle();
    set_p0(1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
    #1;
    check1("wr_p0_ready", bus.p0_ready, 1'b1);
    check1("wr_p1_ready", bus.p1_ready, 1'b0);

    cyc();
    idle();
    #1;
    check1 ("wr_mem_en",    bus.mem_en, 1'b1);
    check1 ("wr_mem_we",    bus.mem_we, 1'b1);
    check32("wr_mem_addr",  32'(bus.mem_addr), 32'h005);
    check32("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check1 ("wr_busy",      bus.busy, 1'b1);

    cyc();
    set_p0(1'b1, 1'b0, 10'h005, 32'h0);
    #1;
    check1 ("rd_p0_ready",      bus.p0_ready, 1'b1);
    check1 ("idle_mem_en",      bus.mem_en, 1'b0);
    check1 ("hold_mem_we",      bus.mem_we, 1'b1);
    check32("hold_mem_addr",    32'(bus.mem_addr), 32'h005);
    check32("hold_mem_wdata",   bus.mem_wdata, 32'hDEADBEEF);

    cyc();
    idle();
    #1;
    check1("rd_mem_en",      bus.mem_en, 1'b1);
    check1("rd_mem_we",      bus.mem_we, 1'b0);
    check1("rd_early_rvalid", bus.p0_rvalid, 1'b0);

    cyc();
    #1;
    check1 ("rd_p0_rvalid", bus.p0_rvalid, 1'b1);
    check32("rd_p0_rdata",  bus.p0_rdata, 32'hDEADBEEF);
    check1 ("rd_p1_rvalid", bus.p1_rvalid, 1'b0);

    cyc();
    #1;
    check1("rd_rvalid_once", bus.p0_rvalid, 1'b0);
    check1("rd_busy_clear",  bus.busy, 1'b0);

    // Write by p1 followed immediately by read of same address by p0
    cyc();
    set_p1(1'b1, 1'b1, 10'h3FF, 32'h12345678);
    #1;
    check1("hz_p1_ready", bus.p1_ready, 1'b1);
    check1("hz_p0_ready", bus.p0_ready, 1'b0);

    cyc();
    idle();
    set_p0(1'b1, 1'b0, 10'h3FF, 32'h0);
    #1;
    check1 ("hz_rd_ready", bus.p0_ready, 1'b1);
    check32("hz_wr_addr",  32'(bus.mem_addr), 32'h3FF);

    cyc();
    idle();
    #1;
    check1("hz_no_rvalid", bus.p0_rvalid, 1'b0);

    cyc();
    #1;
    check1 ("hz_p0_rvalid", bus.p0_rvalid, 1'b1);
    check32("hz_p0_rdata",  bus.p0_rdata, 32'h12345678);
    check1 ("hz_p1_rvalid", bus.p1_rvalid, 1'b0);

    // Address corners
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i < 4) set_p0(1'b1, c_we[i], c_addr[i], c_data[i]);
      else       idle();
      #1;
      if (i < 4) check1("corner_ready", bus.p0_ready, 1'b1);
      if (i >= 4) begin
        check1 ("corner_rvalid", bus.p0_rvalid, 1'b1);
        check32("corner_rdata",  bus.p0_rdata, (i == 4) ? 32'hFFFFFFFF : 32'h00000000);
      end
    end
    cyc();
    #1;
    check1("corner_rvalid_end", bus.p0_rvalid, 1'b0);

    // Reset while a p1 read is in flight
    cyc();
    set_p1(1'b1, 1'b0, 10'h005, 32'h0);
    #1;
    check1("mr_p1_ready", bus.p1_ready, 1'b1);

    cyc();
    ARESET = 1'b1;
    idle();
    set_p0(1'b1, 1'b0, 10'h005, 32'h0);
    #1;
    check1("mr_rst_p0_ready", bus.p0_ready, 1'b0);
    check1("mr_rst_mem_en",   bus.mem_en, 1'b1);
    check1("mr_rst_p1_rvalid", bus.p1_rvalid, 1'b0);

    cyc();
    ARESET = 1'b0;
    idle();
    #1;
    check1 ("mr_busy",      bus.busy, 1'b0);
    check1 ("mr_mem_en",    bus.mem_en, 1'b0);
    check32("mr_mem_addr",  32'(bus.mem_addr), 32'h0);
    check1 ("mr_p1_rvalid", bus.p1_rvalid, 1'b0);
`ifdef MEM_ARB_RR_EN
    check1 ("mr_rr_ptr",    dut.rr_ptr, 1'b0);
`endif

    cyc();
    #1;
    check1("mr_p1_rvalid_late", bus.p1_rvalid, 1'b0);

    // Contention: both ports hold reads for 4 cycles
`ifdef MEM_ARB_RR_EN
    exp_g0 = 4'b0101;
    exp_g1 = 4'b1010;
`else
    exp_g0 = 4'b1111;
    exp_g1 = 4'b0000;
`endif
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i < 4) begin
        set_p0(1'b1, 1'b0, 10'h005, 32'h0);
        set_p1(1'b1, 1'b0, 10'h005, 32'h0);
      end else begin
        idle();
      end
      #1;
      if (i < 4) begin
        check1("cont_p0_ready", bus.p0_ready, exp_g0[i]);
        check1("cont_p1_ready", bus.p1_ready, exp_g1[i]);
      end
      if (i >= 2) begin
        check1("cont_p0_rvalid", bus.p0_rvalid, exp_g0[i-2]);
        check1("cont_p1_rvalid", bus.p1_rvalid, exp_g1[i-2]);
      end
    end

    // Throughput: 100 back-to-back p0 writes
    hs_cnt = 0;
    en_cnt = 0;
    for (int i = 0; i <= 100; i++) begin
      cyc();
      if (i < 100) set_p0(1'b1, 1'b1, 10'(i + 16), 32'(i * 7 + 3));
      else         idle();
      #1;
      if (i < 100 && bus.p0_ready) hs_cnt++;
      if (i >= 1 && bus.mem_en && bus.mem_we &&
          bus.mem_addr == 10'(i + 15) && bus.mem_wdata == 32'((i - 1) * 7 + 3))
        en_cnt++;
    end
    check32("thru_handshakes", 32'(hs_cnt), 32'd100);
    check32("thru_mem_en",     32'(en_cnt), 32'd100);
    cyc();
    #1;
    check1("thru_mem_en_end", bus.mem_en, 1'b0);
    check1("thru_busy_end",   bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
